// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard receiver: oversampled pin synchronizers, 11-bit frame check,
// and an 8-entry first-word-fall-through scan-code FIFO popped by the CPU read strobe.
module ps2_kbd_fifo #(
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rdn,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT);

    logic [2:0]  clk_sync;
    logic [1:0]  data_sync;
    logic        fall;

    logic [9:0]  shift_buf;
    logic [3:0]  bit_cnt;
    logic [15:0] idle_cnt;
    logic        frame_done;
    logic        frame_ok;

    logic [7:0]  fifo [0:7];
    logic [2:0]  w_ptr;
    logic [2:0]  r_ptr;
    logic [3:0]  cnt;
    logic        pop;
    logic        push_req;
    logic        push_ok;

    // ps2_clk sync resets to all-ones so releasing reset never looks like a falling edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments make each stage take the previous stage's old value.
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign fall = (clk_sync[2:1] == 2'b10);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            shift_buf <= '0;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
        end else if (fall) begin
            idle_cnt <= '0;
            if (bit_cnt == 4'd10) begin
                bit_cnt <= '0;
            end else begin
                shift_buf <= {data_sync[1], shift_buf[9:1]};
                bit_cnt   <= bit_cnt + 4'd1;
            end
        end else if (bit_cnt != 4'd0) begin
            if (idle_cnt == IDLE_LIMIT) begin
                bit_cnt  <= '0;
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 16'd1;
            end
        end else begin
            idle_cnt <= '0;
        end
    end

    // After ten shifts: [0]=start, [8:1]=d0..d7, [9]=parity; the stop bit is still on the synced line.
    assign frame_done = fall && (bit_cnt == 4'd10);
    assign frame_ok   = !shift_buf[0] && data_sync[1] && (^shift_buf[9:1]);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value held (no latch).
        pop      = 1'b0;
        push_req = 1'b0;
        push_ok  = 1'b0;
        if (!rdn && ready)
            pop = 1'b1;
        if (frame_done && frame_ok)
            push_req = 1'b1;
        if (push_req && ((cnt < 4'd8) || pop))
            push_ok = 1'b1;
    end

    // NOTE: storage has no reset; cnt alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_ok)
            fifo[w_ptr] <= shift_buf[8:1];
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push_ok)
                w_ptr <= w_ptr + 3'd1;
            if (pop)
                r_ptr <= r_ptr + 3'd1;
            if (push_ok && !pop)
                cnt <= cnt + 4'd1;
            else if (pop && !push_ok)
                cnt <= cnt - 4'd1;

            // A new error in the same cycle as a pop keeps the flag set.
            if (push_req && !push_ok)
                overflow <= 1'b1;
            else if (pop)
                overflow <= 1'b0;

            if (frame_done && !frame_ok)
                frame_err <= 1'b1;
            else if (pop)
                frame_err <= 1'b0;
        end
    end

    assign ready = (cnt != 4'd0);
    assign data  = ready ? fifo[r_ptr] : 8'h00;

endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Bench for ps2_kbd_fifo: drives PS/2 frames on the pins and checks outputs every cycle
// against a frame/queue model, plus literal expectations at key points.
module tb_ps2_kbd_fifo;

    localparam int TMO  = 200;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk_pin = 1'b1;
    logic       ps2_data_pin = 1'b1;
    logic       rdn = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    int tests = 0;
    int fails = 0;

    ps2_kbd_fifo #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .ps2_clk   (ps2_clk_pin),
        .ps2_data  (ps2_data_pin),
        .rdn       (rdn),
        .data      (data),
        .ready     (ready),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int age;
        bit d;
    } fall_t;

    logic [7:0] mq[$];
    fall_t      pend[$];
    bit         bits[$];
    int         idle = 0;
    bit         m_ovf = 1'b0;
    bit         m_err = 1'b0;
    bit         prev_clk = 1'b1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        pend.delete();
        bits.delete();
        idle     = 0;
        m_ovf    = 1'b0;
        m_err    = 1'b0;
        prev_clk = ps2_clk_pin;
    endtask

    // State after one rising edge: pin falls land 3 edges later, frames are judged on
    // their 11th bit, the CPU pops when rdn is low and something is buffered.
    task automatic model_update();
        bit pop_now, full_pre, detect, dbit, good;
        logic [7:0] d;
        pop_now  = !rdn && (mq.size() != 0);
        full_pre = (mq.size() == 8);
        detect   = 1'b0;
        dbit     = 1'b0;
        foreach (pend[i]) pend[i].age++;
        if (prev_clk && !ps2_clk_pin)
            pend.push_back('{age: 1, d: ps2_data_pin});
        prev_clk = ps2_clk_pin;
        if (pend.size() != 0 && pend[0].age == 3) begin
            detect = 1'b1;
            dbit   = pend[0].d;
            void'(pend.pop_front());
        end
        if (pop_now) begin
            void'(mq.pop_front());
            m_ovf = 1'b0;
            m_err = 1'b0;
        end
        if (detect) begin
            idle = 0;
            bits.push_back(dbit);
            if (bits.size() == 11) begin
                for (int k = 0; k < 8; k++) d[k] = bits[k + 1];
                good = !bits[0] && bits[10] && ((^d) ^ bits[9]);
                if (!good)
                    m_err = 1'b1;
                else if (!full_pre || pop_now)
                    mq.push_back(d);
                else
                    m_ovf = 1'b1;
                bits.delete();
            end
        end else if (bits.size() != 0) begin
            idle++;
            if (idle > TMO) begin
                bits.delete();
                idle = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        if (clrn) begin
            #1;
            if (clrn) begin
                check("cyc_data", data, (mq.size() != 0) ? mq[0] : 8'h00);
                check("cyc_ready", {7'd0, ready}, {7'd0, mq.size() != 0});
                check("cyc_overflow", {7'd0, overflow}, {7'd0, m_ovf});
                check("cyc_frame_err", {7'd0, frame_err}, {7'd0, m_err});
            end
        end
    end

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                              input bit pop_at_commit);
        logic [10:0] w;
        w = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data_pin = w[i];
            repeat (HALF) tick();
            ps2_clk_pin = 1'b0;
            for (int j = 0; j < HALF; j++) begin
                if (pop_at_commit && i == 10 && j == 2) rdn = 1'b0;
                else if (pop_at_commit && i == 10 && j == 3) rdn = 1'b1;
                tick();
            end
            ps2_clk_pin = 1'b1;
        end
        repeat (HALF) tick();
    endtask

    task automatic pop_read(output logic [7:0] v);
        v   = data;
        rdn = 1'b0;
        tick();
        rdn = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;

        #1;
        check("rst_data", data, 8'h00);
        check("rst_ready", {7'd0, ready}, 8'h00);
        check("rst_overflow", {7'd0, overflow}, 8'h00);
        check("rst_frame_err", {7'd0, frame_err}, 8'h00);
        @(negedge clk);
        clrn = 1'b1;
        model_reset();
        repeat (5) tick();

        // Single good frame, then one pop.
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        check("t1_ready", {7'd0, ready}, 8'h01);
        check("t1_data", data, 8'h1C);
        check("t1_flags", {6'd0, overflow, frame_err}, 8'h00);
        pop_read(v);
        check("t1_read", v, 8'h1C);
        check("t1_ready_after", {7'd0, ready}, 8'h00);
        check("t1_data_after", data, 8'h00);

        // Bad parity, then a good frame and a pop clears the error.
        send_frame(8'h1C, 1'b1, 11, 1'b0);
        check("t2_ready", {7'd0, ready}, 8'h00);
        check("t2_frame_err", {7'd0, frame_err}, 8'h01);
        send_frame(8'h32, 1'b0, 11, 1'b0);
        check("t2_err_sticky", {7'd0, frame_err}, 8'h01);
        pop_read(v);
        check("t2_read", v, 8'h32);
        check("t2_err_cleared", {7'd0, frame_err}, 8'h00);

        // Nine frames overflow an eight-entry FIFO.
        for (int k = 1; k <= 9; k++) send_frame(8'(k), 1'b0, 11, 1'b0);
        check("t3_overflow", {7'd0, overflow}, 8'h01);
        check("t3_head", data, 8'h01);
        for (int k = 1; k <= 8; k++) begin
            pop_read(v);
            check("t3_read", v, 8'(k));
            if (k == 1) check("t3_ovf_cleared", {7'd0, overflow}, 8'h00);
        end
        check("t3_empty", {7'd0, ready}, 8'h00);

        // Full FIFO with a pop on the exact commit edge accepts the push.
        for (int k = 1; k <= 8; k++) send_frame(8'(k), 1'b0, 11, 1'b0);
        send_frame(8'h0A, 1'b0, 11, 1'b1);
        check("t4_head", data, 8'h02);
        check("t4_overflow", {7'd0, overflow}, 8'h00);
        for (int k = 2; k <= 9; k++) begin
            pop_read(v);
            check("t4_read", v, (k == 9) ? 8'h0A : 8'(k));
        end
        check("t4_empty", {7'd0, ready}, 8'h00);

        // Partial frame abandoned by the idle timeout.
        send_frame(8'h55, 1'b0, 5, 1'b0);
        repeat (250) tick();
        send_frame(8'hF0, 1'b0, 11, 1'b0);
        check("t5_data", data, 8'hF0);
        check("t5_frame_err", {7'd0, frame_err}, 8'h00);
        pop_read(v);
        check("t5_read", v, 8'hF0);

        // Reset mid-frame with codes buffered.
        send_frame(8'h11, 1'b0, 11, 1'b0);
        send_frame(8'h22, 1'b0, 11, 1'b0);
        send_frame(8'h33, 1'b0, 11, 1'b0);
        send_frame(8'h44, 1'b0, 4, 1'b0);
        clrn = 1'b0;
        #1;
        check("t6_rst_data", data, 8'h00);
        check("t6_rst_ready", {7'd0, ready}, 8'h00);
        check("t6_rst_flags", {6'd0, overflow, frame_err}, 8'h00);
        @(negedge clk);
        clrn = 1'b1;
        model_reset();
        send_frame(8'h5A, 1'b0, 11, 1'b0);
        check("t6_data", data, 8'h5A);
        pop_read(v);
        check("t6_read", v, 8'h5A);
        check("t6_empty", {7'd0, ready}, 8'h00);

        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_fifo.md
# ps2_kbd_fifo

PS/2 keyboard receiver with an 8-entry scan-code FIFO. It sits on the CPU I/O bus, in the i/o space a0000000-bfffffff, and is read by the CPU through the active-low `io_rdn` strobe. The block oversamples the keyboard's `ps2_clk`/`ps2_data` lines on the system clock, assembles and checks 11-bit frames, and buffers valid scan codes until the CPU pops them.

## Interface
Parameters:
- `TIMEOUT`, default 50000: number of `clk` cycles without a `ps2_clk` falling edge before a partial frame is discarded.

Ports:
- `clk` in 1: system clock, the same clock as the CPU; one clock domain.
- `clrn` in 1: reset, asynchronous, active-low.
- `ps2_clk` in 1: keyboard clock pin, asynchronous to `clk`.
- `ps2_data` in 1: keyboard data pin, asynchronous to `clk`.
- `rdn` in 1: read strobe, active-low, driven by the CPU `io_rdn`.
- `data` out 8: scan code at the FIFO head; 8'h00 when empty.
- `ready` out 1: FIFO non-empty.
- `overflow` out 1: sticky; set when a valid frame is dropped because the FIFO is full.
- `frame_err` out 1: sticky; set on a start, stop or parity error.

## Operation
- Synchronizers:
  - `ps2_clk` passes through a 3-FF shift register, `ps2_data` through a 2-FF register.
  - Falling edge = the two oldest `ps2_clk` sync bits equal 2'b10.
- Frame assembly:
  - Frame = start(0), d0..d7 (LSB first), odd parity, stop(1).
  - On each falling edge, shift the synced data into a 10-bit buffer and increment the 4-bit bit count.
  - On the 11th edge (count == 10), check the frame and reset count to 0.
- Frame check: start==0, stop==1, and XOR of d0..d7 and parity == 1.
  - Pass: push d[7:0]; if the push is refused, set `overflow`.
  - Fail: drop the frame and set `frame_err`.
- Timeout:
  - A 16-bit idle counter clears on every falling edge and increments while count != 0.
  - When it reaches `TIMEOUT`, count returns to 0 and the partial frame is discarded. No flag is set.
- FIFO:
  - 8 entries; 3-bit `w_ptr`/`r_ptr` that wrap 7 -> 0; 4-bit `cnt` from 0..8.
  - `ready` = (cnt != 0).
  - `data` = `ready` ? fifo[r_ptr] : 8'h00 (combinational, first-word fall-through).
- Pop: on each `clk` rising edge with `rdn`==0 and `ready`==1, increment `r_ptr` and decrement `cnt`.
  - If `rdn` is held low for N cycles, the FIFO pops up to N entries.
  - `rdn` low while empty has no effect.
- Push acceptance: a push is accepted if cnt < 8, or if cnt == 8 and a pop occurs in the same cycle.
- Simultaneous push and pop: `cnt` is unchanged and both pointers advance.
- Flag clearing: `overflow` and `frame_err` clear on any successful pop. If set and cleared in the same cycle, set wins.

## Timing
- Reset (asynchronous, `clrn` low):
  - pointers, `cnt`, bit count, idle counter, flags and synchronizers go to 0.
  - Synchronizers for `ps2_clk` go to all-ones, so release does not produce a false edge.
  - Outputs: `data`=8'h00, `ready`=0, `overflow`=0, `frame_err`=0.
  - FIFO storage is not reset.
- Reset mid-frame discards the partial frame and all buffered codes.
- Edge latency: a `ps2_clk` pin fall is detected on the 3rd `clk` rising edge after it (sync plus edge register).
- Data is sampled from the 2-FF synced `ps2_data` on the detect cycle. At that point it has settled for at least 2 cycles after the pin edge.
- Commit: `ready`/`data` update on the clock edge that processes the 11th falling edge. They are visible the following cycle, 4 `clk` after the pin fall.
- Pop: `data` shows the next entry in the cycle after the `rdn`-low edge. The CPU's `lw` samples `data` combinationally in the same cycle `rdn` is low, so it captures the old head.
- Minimum: `TIMEOUT` must exceed the longest PS/2 bit period in `clk` cycles (PS/2 clock ≥10 kHz → ≥100 µs).

## Test plan
- Frame 0x1C, parity=0 (bits 0,0,0,1,1,1,0,0,0,0,1 on the wire; PS/2 period 40 clk, `TIMEOUT`=200) → `ready`=1, `data`=8'h1C, flags 0. One cycle of `rdn`=0 → `ready`=0, `data`=8'h00.
- Frame 0x1C with parity=1 → `ready` stays 0, `frame_err`=1. A following good frame 0x32 then a pop → `data` read 8'h32, `frame_err`=0 after the pop.
- Nine frames 0x01..0x09 with no reads → `cnt`=8, `overflow`=1. Eight pops return 0x01..0x08 in order, 0x09 is lost, and `overflow` clears after the first pop.
- FIFO full, `rdn` held low on the exact cycle frame 0x0A commits → push accepted, `overflow`=0, and the head advances to 0x02.
- Five bits of a frame, then idle for 250 clk, then a full frame 0xF0 → `data`=8'hF0, `frame_err`=0.
- Three codes buffered, then `clrn` pulsed low mid-frame → all outputs 0 immediately. A fresh frame 0x5A then yields only 0x5A.
